// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control unit.
// Sequences fetch/decode/execute/writeback for lw, sw, R-type, I-type ALU,
// beq and jal, stalling on mem_ready during memory accesses.
// Optional build macro MAIN_FSM_ILLEGAL_TRAP_EN: unknown opcodes go to a
// sticky TRAP state and the illegal_instr port is present.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op[6:0]         opcode from the instruction register
//   zero            ALU zero flag
//   mem_ready       memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0],
//   ALUSrcB[1:0], ALUOp[1:0], RegWrite   datapath controls
//   state_o[3:0]    current state (debug)
//   illegal_instr   in TRAP (only with MAIN_FSM_ILLEGAL_TRAP_EN)
module main_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [3:0] state_o
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  localparam logic [3:0] TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic       pc_update;
  logic       branch;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and control decode; everything defaults to 0 / stay
  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;  // treat as no-op, PC already advanced
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;  // held through wait cycles
        if (mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;  // sticky until reset
`endif
      default: state_d = FETCH;  // unreachable encodings recover
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);
  assign state_o = state_q;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed self-checking bench for main_fsm.
// Control vector packing: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,
// ALUSrcA,ALUSrcB,ALUOp,RegWrite}.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_o;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int errors = 0;
  int checks = 0;

  // Expected control vectors per state
  localparam logic [13:0] V_FETCH   = 14'b1_0_0_1_10_00_10_00_0;
  localparam logic [13:0] V_FETCHW  = 14'b0_0_0_0_10_00_10_00_0;
  localparam logic [13:0] V_DECODE  = 14'b0_0_0_0_00_01_01_00_0;
  localparam logic [13:0] V_MEMADR  = 14'b0_0_0_0_00_10_01_00_0;
  localparam logic [13:0] V_MEMREAD = 14'b0_1_0_0_00_00_00_00_0;
  localparam logic [13:0] V_MEMWB   = 14'b0_0_0_0_01_00_00_00_1;
  localparam logic [13:0] V_MEMWR   = 14'b0_1_1_0_00_00_00_00_0;
  localparam logic [13:0] V_EXECR   = 14'b0_0_0_0_00_10_00_10_0;
  localparam logic [13:0] V_EXECI   = 14'b0_0_0_0_00_10_01_10_0;
  localparam logic [13:0] V_ALUWB   = 14'b0_0_0_0_00_00_00_00_1;
  localparam logic [13:0] V_BEQ_T   = 14'b1_0_0_0_00_10_00_01_0;
  localparam logic [13:0] V_BEQ_N   = 14'b0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] V_JAL     = 14'b1_0_0_0_00_01_10_00_0;
  localparam logic [13:0] V_ZERO    = 14'b0;

  logic [13:0] ctrl;
  assign ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, RegWrite};

  main_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .state_o(state_o)
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check state and full control vector after letting inputs settle
  task automatic expect_st(input string tag, input logic [3:0] st,
                           input logic [13:0] v);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(v));
  endtask

  initial begin
    rst = 1'b1; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    expect_st("reset", 4'd0, V_FETCH);
    rst = 1'b0;

    // R-type: 0,1,6,8,0
    expect_st("r.fetch", 4'd0, V_FETCH);
    tick(); expect_st("r.decode", 4'd1, V_DECODE);
    tick(); expect_st("r.execr", 4'd6, V_EXECR);
    tick(); expect_st("r.aluwb", 4'd8, V_ALUWB);
    tick(); expect_st("r.done", 4'd0, V_FETCH);

    // FETCH wait: enables drop and state holds
    mem_ready = 1'b0;
    expect_st("fw.wait0", 4'd0, V_FETCHW);
    tick(); expect_st("fw.wait1", 4'd0, V_FETCHW);

    // lw with 3 wait cycles in MEMREAD
    op = 7'b0000011; mem_ready = 1'b1;
    expect_st("lw.fetch", 4'd0, V_FETCH);
    tick(); expect_st("lw.decode", 4'd1, V_DECODE);
    tick(); expect_st("lw.memadr", 4'd2, V_MEMADR);
    tick(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_st("lw.memread_wait", 4'd3, V_MEMREAD);
      tick();
    end
    mem_ready = 1'b1;
    expect_st("lw.memread_go", 4'd3, V_MEMREAD);
    tick(); expect_st("lw.memwb", 4'd4, V_MEMWB);
    tick(); expect_st("lw.done", 4'd0, V_FETCH);

    // addi
    op = 7'b0010011;
    tick(); expect_st("i.decode", 4'd1, V_DECODE);
    tick(); expect_st("i.execi", 4'd7, V_EXECI);
    tick(); expect_st("i.aluwb", 4'd8, V_ALUWB);
    tick(); expect_st("i.done", 4'd0, V_FETCH);

    // beq taken
    op = 7'b1100011; zero = 1'b1;
    tick(); expect_st("beq1.decode", 4'd1, V_DECODE);
    tick(); expect_st("beq1.beq", 4'd9, V_BEQ_T);
    tick(); expect_st("beq1.done", 4'd0, V_FETCH);

    // beq not taken
    zero = 1'b0;
    tick(); expect_st("beq0.decode", 4'd1, V_DECODE);
    tick(); expect_st("beq0.beq", 4'd9, V_BEQ_N);
    tick(); expect_st("beq0.done", 4'd0, V_FETCH);

    // jal: 0,1,10,8,0
    op = 7'b1101111;
    tick(); expect_st("jal.decode", 4'd1, V_DECODE);
    tick(); expect_st("jal.jal", 4'd10, V_JAL);
    tick(); expect_st("jal.aluwb", 4'd8, V_ALUWB);
    tick(); expect_st("jal.done", 4'd0, V_FETCH);

    // sw completing normally
    op = 7'b0100011;
    tick(); expect_st("sw.decode", 4'd1, V_DECODE);
    tick(); expect_st("sw.memadr", 4'd2, V_MEMADR);
    tick(); expect_st("sw.memwrite", 4'd5, V_MEMWR);
    tick(); expect_st("sw.done", 4'd0, V_FETCH);

    // sw stalled, reset on second wait cycle
    tick(); expect_st("swr.decode", 4'd1, V_DECODE);
    tick(); expect_st("swr.memadr", 4'd2, V_MEMADR);
    tick(); mem_ready = 1'b0;
    expect_st("swr.wait0", 4'd5, V_MEMWR);
    tick(); rst = 1'b1;
    expect_st("swr.wait1", 4'd5, V_MEMWR);
    tick(); rst = 1'b0;
    expect_st("swr.reset", 4'd0, V_FETCHW);
    mem_ready = 1'b1;

    // Unknown opcode
    op = 7'b1111111;
    tick(); expect_st("ill.decode", 4'd1, V_DECODE);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      tick(); expect_st("ill.trap", 4'd11, V_ZERO);
      chk("ill.flag", 32'(illegal_instr), 32'd1);
    end
    rst = 1'b1;
    tick(); rst = 1'b0;
    expect_st("ill.reset", 4'd0, V_FETCH);
    chk("ill.flag_clr", 32'(illegal_instr), 32'd0);
`else
    tick(); expect_st("ill.noop", 4'd0, V_FETCH);
    tick(); expect_st("ill.decode2", 4'd1, V_DECODE);
    rst = 1'b1;
    tick(); rst = 1'b0;
    expect_st("ill.reset", 4'd0, V_FETCH);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; all encodings are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 op  in  7  opcode of the instruction register contents.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-007 PCWrite  out  1  PC register enable.
REQ-008 AdrSrc  out  1  memory address select; 0 = PC, 1 = ALU result register.
REQ-009 MemWrite  out  1  data memory write strobe.
REQ-010 IRWrite  out  1  instruction register enable.
REQ-011 ResultSrc  out  2  result mux select; 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-012 ALUSrcA  out  2  ALU A select; 00 = PC, 01 = OldPC, 10 = rs1.
REQ-013 ALUSrcB  out  2  ALU B select; 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-014 ALUOp  out  2  feeds the ALU decoder; 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-015 RegWrite  out  1  register file write enable.
REQ-016 state_o  out  4  current state encoding, for debug.
REQ-017 illegal_instr  out  1  illegal-opcode flag; exists only when the macro in REQ-035 is defined.

Function
REQ-018 Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-019 Outputs are decoded from state only, except PCWrite and the FETCH enables; every output not listed for a state is 0.
REQ-020 Internal PCUpdate and Branch terms: PCWrite = PCUpdate | (Branch & zero).
REQ-021 FETCH:
  - outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other opcode -> per REQ-035.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-024 MEMREAD: AdrSrc=1, ResultSrc=00; hold while mem_ready=0, then go to MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-026 MEMWRITE:
  - outputs: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held through every wait cycle.
  - go to FETCH on mem_ready=1.
REQ-027 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-028 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-030 BEQ:
  - outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - PCWrite = zero.
  - next FETCH regardless of zero.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next ALUWB.
REQ-032 Instruction cost with mem_ready tied to 1, in cycles: R/I = 4, lw = 5, sw = 4, beq = 3, jal = 4; each mem_ready=0 cycle adds 1.
REQ-033 Unreachable encodings 12-15 SHALL go to FETCH on the next edge, with all outputs 0.

Reset
REQ-034 rst=1 at a clock edge:
  - state becomes FETCH, overriding any transition, including mid-wait in MEMREAD/MEMWRITE.
  - outputs settle to FETCH values the same cycle.
  - illegal_instr clears to 0.

Configuration
REQ-035 Macro MAIN_FSM_ILLEGAL_TRAP_EN:
  - defined: an unknown opcode in DECODE goes to TRAP. TRAP drives all control outputs 0 and illegal_instr=1, and is left only by rst.
  - undefined: an unknown opcode in DECODE goes to FETCH (no-op, PC already advanced). The TRAP state and the illegal_instr port are absent.

Verification
REQ-036 Directed scenarios:
  - Reset released, mem_ready=1, op=0110011 -> state_o 0,1,6,8,0; RegWrite=1 only in state 8; ALUOp=10 in state 6.
  - op=0000011, mem_ready=0 for 3 cycles in MEMREAD -> state_o 0,1,2,3,3,3,3,4,0; AdrSrc=1 throughout the state-3 cycles.
  - op=1100011: zero=1 -> PCWrite=1 in state 9; zero=0 -> PCWrite=0; both cases return to state 0.
  - op=0100011, mem_ready low 2 cycles in MEMWRITE, rst=1 on the second -> next state_o=0, MemWrite=0.
  - op=1111111, macro defined -> state_o=11, illegal_instr=1 held 10 cycles, cleared by rst; macro undefined -> state_o 1 -> 0.
